// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer.
//   seq_state_t   sequencer FSM state
//   CLS_*         word class in bits [13:12]
//   NOP_WORD      word driven on the datapath bus when nothing is issued
//   HALT_CODE     control sub-code in bits [11:8] that halts execution
//   COND_*        branch condition selects in bits [10:8]
//   cond_eval     resolves a branch condition against the shadow flags
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_FLAG_WAIT,
    ST_HALT
  } seq_state_t;

  localparam logic [1:0] CLS_LOAD = 2'b00;
  localparam logic [1:0] CLS_ALU  = 2'b01;
  localparam logic [1:0] CLS_BR   = 2'b10;
  localparam logic [1:0] CLS_CTL  = 2'b11;

  localparam logic [13:0] NOP_WORD  = 14'h3000;
  localparam logic [3:0]  HALT_CODE = 4'hF;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_N      = 3'b010;
  localparam logic [2:0] COND_C      = 3'b011;
  localparam logic [2:0] COND_V      = 3'b100;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } seq_flags_t;

  // Selects 101..111 never match; 'inv' flips the result, so an inverted
  // "always" is a never-taken branch.
  function automatic logic cond_eval(input logic [2:0] sel, input logic inv,
                                     input seq_flags_t f);
    logic hit;
    case (sel)
      COND_ALWAYS: hit = 1'b1;
      COND_Z:      hit = f.z;
      COND_N:      hit = f.n;
      COND_C:      hit = f.c;
      COND_V:      hit = f.v;
      default:     hit = 1'b0;
    endcase
    return hit ^ inv;
  endfunction

endpackage

// File: rtl/seq_imem.sv
// seq_imem: 14-bit x 2**PC_W instruction memory, one write and one read port,
// both synchronous.
//   clk    system clock
//   we     write strobe
//   waddr  write address
//   wdata  write data
//   raddr  read address, sampled on the rising edge
//   rdata  registered read data
// A write and a read of the same address on one edge return the new word
// (write-first), so a word loaded alongside a start pulse is the one fetched.
// Contents have no reset.
module seq_imem #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PC_W-1:0] waddr,
  input  logic [13:0]     wdata,
  input  logic [PC_W-1:0] raddr,
  output logic [13:0]     rdata
);

  logic [13:0] mem [2**PC_W];
  logic [13:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata_reg <= wdata;
    end else begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 14-bit words from an internal memory, forwards
// load/ALU words to dataPath and executes branch/control words itself.
//   clk, rst_n          clock; synchronous active-low reset
//   start               run from PC 0 (accepted in IDLE or HALT)
//   prog_we/addr/data   memory write port (accepted in IDLE or HALT)
//   flag_*              registered dataPath flags, latched in FLAG_WAIT
//   instruction         registered word to dataPath (NOP when idle)
//   instr_valid         registered, high for one cycle per issued word
//   pc, busy, halted    status
//   retired_cnt         words completed in EXEC; counted only when the
//                       macro SEQ_PERF_CNT_EN is defined, otherwise 0
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [13:0]     prog_data,
  input  logic            flag_zero,
  input  logic            flag_negative,
  input  logic            flag_carry,
  input  logic            flag_overflow,
  output logic [13:0]     instruction,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired_cnt
);

  seq_state_t      state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [13:0]     instr_reg, instr_next;
  logic            valid_reg, valid_next;
  seq_flags_t      flags_reg;
  logic [13:0]     imem_rdata;
  logic            imem_we;
  logic [1:0]      cls;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_inc;

  assign imem_we   = prog_we && (state_reg == ST_IDLE || state_reg == ST_HALT);
  assign cls       = imem_rdata[13:12];
  assign br_target = PC_W'(imem_rdata[7:0]);
  assign pc_inc    = pc_reg + PC_W'(1);

  // The memory is addressed with the next PC, so the word for a FETCH cycle
  // is already on rdata during FETCH; that lets the issued word be loaded
  // into the output register at the FETCH->EXEC edge and appear during EXEC.
  seq_imem #(.PC_W(PC_W)) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_next),
    .rdata (imem_rdata)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = NOP_WORD;
    valid_next = 1'b0;
    case (state_reg)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_next = ST_FETCH;
          pc_next    = '0;
        end
      end
      ST_FETCH: begin
        state_next = ST_EXEC;
        if (cls == CLS_LOAD || cls == CLS_ALU) begin
          instr_next = imem_rdata;
          valid_next = 1'b1;
        end
      end
      ST_EXEC: begin
        state_next = ST_FETCH;
        pc_next    = pc_inc;
        case (cls)
          CLS_ALU: state_next = ST_FLAG_WAIT;
          CLS_BR: begin
            if (cond_eval(imem_rdata[10:8], imem_rdata[11], flags_reg)) begin
              pc_next = br_target;
            end
          end
          CLS_CTL: begin
            if (imem_rdata[11:8] == HALT_CODE) begin
              state_next = ST_HALT;
              pc_next    = pc_reg;
            end
          end
          default: ;
        endcase
      end
      ST_FLAG_WAIT: state_next = ST_FETCH;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      instr_reg <= NOP_WORD;
      valid_reg <= 1'b0;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      // dataPath registers flags at the end of the ALU issue cycle, so they
      // are stable here, one cycle later.
      if (state_reg == ST_FLAG_WAIT) begin
        flags_reg <= '{z: flag_zero, n: flag_negative,
                       c: flag_carry, v: flag_overflow};
      end
    end
  end

  assign instruction = instr_reg;
  assign instr_valid = valid_reg;
  assign pc          = pc_reg;
  assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_EXEC) ||
                       (state_reg == ST_FLAG_WAIT);
  assign halted      = (state_reg == ST_HALT);

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] retired_reg;
  logic        start_accept;

  assign start_accept = start && (state_reg == ST_IDLE || state_reg == ST_HALT);

  always_ff @(posedge clk) begin
    if (!rst_n || start_accept) begin
      retired_reg <= '0;
    end else if (state_reg == ST_EXEC && retired_reg != 16'hFFFF) begin
      retired_reg <= retired_reg + 16'd1;
    end
  end

  assign retired_cnt = retired_reg;
`else
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed bench for instr_sequencer. Expected issued
// words (word + issue cycle) are queued when a program is started and popped
// by a monitor whenever the DUT raises instr_valid. A second instance with
// PC_W=4 covers PC wrap and branch-target truncation.
module tb_instr_sequencer;

  localparam logic [13:0] NOP  = 14'h3000;
  localparam logic [13:0] HALT = 14'h3F00;
`ifdef SEQ_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, prog_we;
  logic [7:0]  prog_addr;
  logic [13:0] prog_data;
  logic        flag_zero, flag_negative, flag_carry, flag_overflow;
  logic [13:0] instruction;
  logic        instr_valid, busy, halted;
  logic [7:0]  pc;
  logic [15:0] retired_cnt;

  logic        rst_n4, start4, we4;
  logic [3:0]  addr4;
  logic [13:0] data4;
  logic [13:0] instruction4;
  logic        instr_valid4, busy4, halted4;
  logic [3:0]  pc4;
  logic [15:0] retired_cnt4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [13:0] w;
    int          c;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_sequencer #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .flag_zero(flag_zero), .flag_negative(flag_negative),
    .flag_carry(flag_carry), .flag_overflow(flag_overflow),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .busy(busy), .halted(halted), .retired_cnt(retired_cnt)
  );

  instr_sequencer #(.PC_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .start(start4), .prog_we(we4),
    .prog_addr(addr4), .prog_data(data4),
    .flag_zero(flag_zero), .flag_negative(flag_negative),
    .flag_carry(flag_carry), .flag_overflow(flag_overflow),
    .instruction(instruction4), .instr_valid(instr_valid4), .pc(pc4),
    .busy(busy4), .halted(halted4), .retired_cnt(retired_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_taken(input logic [3:0] code, input logic [3:0] zncv);
    bit c;
    case (code[2:0])
      3'd0:    c = 1'b1;
      3'd1:    c = zncv[3];
      3'd2:    c = zncv[2];
      3'd3:    c = zncv[1];
      3'd4:    c = zncv[0];
      default: c = 1'b0;
    endcase
    return c ^ code[3];
  endfunction

  // Scoreboard side: every issue must match the head of the queue in both
  // word and cycle; otherwise the bus must carry NOP.
  always @(negedge clk) begin
    if (mon_en) begin
      if (instr_valid) begin
        if (q.size() == 0) begin
          chk("issue_unexpected", 32'(instr_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("issue_word", 32'(instruction), 32'(e.w));
          chk("issue_cycle", cyc, e.c);
        end
      end else begin
        chk("idle_word", 32'(instruction), 32'(NOP));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [13:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start(output int s);
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(output int hcyc);
    int n = 0;
    while (!halted && n < 40) begin
      tick();
      n++;
    end
    hcyc = cyc;
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic set_flags(input logic [3:0] zncv);
    {flag_zero, flag_negative, flag_carry, flag_overflow} = zncv;
  endtask

  initial begin
    int s, h;
    logic [3:0] pats [2];
    pats[0] = 4'b1010;
    pats[1] = 4'b0101;

    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    rst_n4 = 1'b0; start4 = 1'b0; we4 = 1'b0; addr4 = '0; data4 = '0;
    set_flags(4'b0000);
    tick(); tick();
    chk("rst_instr", 32'(instruction), 32'(NOP));
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retired", 32'(retired_cnt), 32'd0);
    rst_n = 1'b1; rst_n4 = 1'b1;
    tick();
    mon_en = 1'b1;

    // Basic program, with a write and a start attempted while busy.
    load(8'd0, 14'h0AF0);
    load(8'd1, 14'h1A11);
    load(8'd2, HALT);
    pulse_start(s);
    q.push_back('{14'h0AF0, s + 2});
    q.push_back('{14'h1A11, s + 4});
    load(8'd1, 14'h0000);          // FETCH cycle: must be ignored
    tick(); tick(); tick();        // now in FLAG_WAIT
    start = 1'b1; tick(); start = 1'b0;
    wait_halt(h);
    chk("p1_halt_cyc", h, s + 8);
    chk("p1_pc", 32'(pc), 32'd2);
    chk("p1_retired", 32'(retired_cnt), 32'(3 * PERF));

    // Rerun sees the original word 1; reset lands in FLAG_WAIT.
    set_flags(4'b1000);
    pulse_start(s);
    q.push_back('{14'h0AF0, s + 2});
    q.push_back('{14'h1A11, s + 4});
    tick(); tick(); tick(); tick();
    chk("fw_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_instr", 32'(instruction), 32'(NOP));
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    chk("mid_rst_retired", 32'(retired_cnt), 32'd0);

    // Memory survives reset; Z=1 is latched by this run's FLAG_WAIT.
    pulse_start(s);
    q.push_back('{14'h0AF0, s + 2});
    q.push_back('{14'h1A11, s + 4});
    wait_halt(h);
    chk("p2_halt_cyc", h, s + 8);
    chk("p2_pc", 32'(pc), 32'd2);
    chk("p2_retired", 32'(retired_cnt), 32'(3 * PERF));

    // Branch on shadow Z (=1) while the live flag reads 0.
    set_flags(4'b0000);
    load(8'd0, 14'h2105);
    load(8'd1, HALT);
    load(8'd5, HALT);
    pulse_start(s);
    wait_halt(h);
    chk("shadow_halt_cyc", h, s + 5);
    chk("shadow_pc", 32'(pc), 32'd5);

    // Reset clears the shadow flags even though the live Z is now 1.
    set_flags(4'b1000);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    pulse_start(s);
    wait_halt(h);
    chk("shadow_clr_pc", 32'(pc), 32'd1);

    // Never-taken (inverted always), then always to 3.
    load(8'd0, 14'h2800);
    load(8'd1, 14'h2003);
    load(8'd2, HALT);
    load(8'd3, HALT);
    pulse_start(s);
    wait_halt(h);
    chk("br_halt_cyc", h, s + 7);
    chk("br_pc", 32'(pc), 32'd3);
    chk("br_retired", 32'(retired_cnt), 32'(3 * PERF));

    // Every condition/inversion against two flag patterns.
    load(8'd0, 14'h1000);
    load(8'd2, HALT);
    load(8'd4, HALT);
    for (int p = 0; p < 2; p++) begin
      set_flags(pats[p]);
      for (int code = 0; code < 16; code++) begin
        logic [3:0] cb;
        cb = code[3:0];
        load(8'd1, {2'b10, cb, 8'd4});
        pulse_start(s);
        q.push_back('{14'h1000, s + 2});
        wait_halt(h);
        chk($sformatf("cond_cyc_p%0d_c%0d", p, code), h, s + 8);
        chk($sformatf("cond_pc_p%0d_c%0d", p, code), 32'(pc),
            exp_taken(cb, pats[p]) ? 32'd4 : 32'd2);
      end
    end

    // PC_W=4: branch target 0x1D truncates to 13, then 15 wraps to 0.
    we4 = 1'b1;
    addr4 = 4'd0;  data4 = 14'h201D; tick();
    addr4 = 4'd13; data4 = NOP; tick();
    addr4 = 4'd14; data4 = NOP; tick();
    addr4 = 4'd15; data4 = NOP; tick();
    we4 = 1'b0;
    start4 = 1'b1; tick(); start4 = 1'b0;
    chk("w4_fetch0", 32'(pc4), 32'd0);
    tick(); tick();
    chk("w4_trunc_pc", 32'(pc4), 32'd13);
    tick(); tick(); tick(); tick(); tick();
    chk("w4_pc15", 32'(pc4), 32'd15);
    tick();
    chk("w4_wrap_pc", 32'(pc4), 32'd0);
    chk("w4_busy", 32'(busy4), 32'd1);
    chk("w4_valid", 32'(instr_valid4), 32'd0);
    rst_n4 = 1'b0; tick(); rst_n4 = 1'b1;

    tick();
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program sequencer that drives the 14-bit `instruction` bus of `dataPath` from a small internal instruction memory. It fetches words in order, forwards datapath-class instructions, and executes branch and control instructions itself using the datapath flags (zero, negative, carry, overflow). It sits between a host or loader port and `dataPath`, and is the only source of `dataPath.instruction`.

## Interface
- `PC_W`, default 8: program counter width; instruction memory depth is 2**PC_W words of 14 bits.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset: one clock, synchronous, active-low.
- `start`  in  1  one-cycle pulse; starts execution at PC 0 from IDLE or HALT.
- `prog_we`  in  1  instruction memory write strobe.
- `prog_addr`  in  PC_W  write address.
- `prog_data`  in  14  write data.
- `flag_zero`, `flag_negative`, `flag_carry`, `flag_overflow`  in  1 each  registered flags from `dataPath`.
- `instruction`  out  14  word presented to `dataPath`.
- `instr_valid`  out  1  high in the cycle a datapath-class word is issued.
- `pc`  out  PC_W  current program counter.
- `busy`  out  1  high in FETCH, EXEC and FLAG_WAIT.
- `halted`  out  1  high in HALT.
- `retired_cnt`  out  16  count of retired instructions. Present only with the macro described under Configuration.

## Operation
- Word classes, selected by bits [13:12]:
  - 00: load. Forwarded to `dataPath`.
  - 01: ALU. Forwarded to `dataPath`.
  - 10: branch. Consumed by the sequencer.
  - 11: control. Consumed by the sequencer.
- Branch: bit [11] inverts the condition; bits [10:8] select it: 000 always, 001 Z, 010 N, 011 C, 100 V, 101–111 never. Bits [7:0] are the absolute target. For PC_W<8 the target is truncated; for PC_W>8 it is zero-extended.
- Control: [11:8]=1111 is HALT. Every other value is NOP.
- NOP encoding is 14'h3000. `instruction` carries NOP in every cycle that does not issue a word; `dataPath` treats class 11 as no-op.
- Shadow flags (Z, N, C, V) are captured only in FLAG_WAIT. Branches evaluate the shadow flags, never the live inputs.
- States and transitions:
  - IDLE: `start` moves to FETCH and sets pc=0.
  - FETCH: presents pc to memory, which has a synchronous read. Moves to EXEC.
  - EXEC: decodes the fetched word.
    - Class 00: issue the word, pc+1, go to FETCH.
    - Class 01: issue the word, pc+1, go to FLAG_WAIT.
    - Branch taken: pc=target. Not taken: pc+1. Either way, go to FETCH.
    - NOP: pc+1, go to FETCH.
    - HALT: pc is held, go to HALT.
  - FLAG_WAIT: one cycle; latches the flags at the end of the cycle, then goes to FETCH.
  - HALT: `start` moves to FETCH with pc=0.
- PC increments wrap modulo 2**PC_W.
- Memory writes are accepted only in IDLE or HALT; `prog_we` in other states is ignored. If `prog_we` and `start` arrive in the same cycle, both take effect, and the first fetch sees the new word.
- `start` in FETCH, EXEC or FLAG_WAIT is ignored.
- Reset, including mid-operation: next state is IDLE. `instruction`=14'h3000, `instr_valid`=0, `pc`=0, `busy`=0, `halted`=0, shadow flags=0, `retired_cnt`=0. Memory contents are not reset and are preserved.

## Timing
- `start` at edge N puts the state in FETCH at N+1. The first word is driven on `instruction` during EXEC, which is cycle N+2.
- Issue cost: class 00 takes 2 cycles. Class 01 takes 3 cycles; flags are sampled 1 cycle after issue, i.e. after `dataPath` registers them. Branches and NOPs take 2 cycles each.
- `instr_valid` and a non-NOP `instruction` are asserted for exactly one cycle per issued word. `instruction` and `instr_valid` are registered outputs.
- A branch immediately after an ALU word sees that ALU word's flags; FLAG_WAIT removes the hazard.

## Configuration
- `SEQ_PERF_CNT_EN` defined: `retired_cnt` counts every word that completes EXEC, including branches and NOPs. The count saturates at 16'hFFFF, clears on reset, and also clears on an accepted `start`.
- Not defined: `retired_cnt` is tied to 0 and no counter logic is generated.

## Structure
- Package `seq_pkg` holds:
  - state enum `seq_state_t`;
  - class constants `CLS_LOAD`=2'b00, `CLS_ALU`=2'b01, `CLS_BR`=2'b10, `CLS_CTL`=2'b11;
  - `NOP_WORD`=14'h3000 and `HALT_CODE`=4'hF;
  - condition select constants.
- One sub-module, `seq_imem`: 14-bit wide, 2**PC_W deep, one synchronous write port and one synchronous read port.

## Test plan
- Load 00_1010_1111_0000, 01_1010_0001_0001, 11_1111_0000_0000; pulse `start` -> word 0 issued with `instr_valid` at start+2, word 1 at start+4, then `halted`=1 with `pc`=2.
- ALU word that makes Z=1, then branch 10_0001_0000_0101 -> pc=5 on the next fetch. With Z=0, pc = branch address+1.
- Branch 10_1000_0000_0000 (negated always) -> never taken, pc+1. Branch 10_0000_0000_0011 (always) -> pc=3.
- With PC_W=4, NOP at address 15 -> pc wraps to 0.
- `rst_n`=0 during FLAG_WAIT -> next cycle IDLE, `instruction`=14'h3000, `busy`=0. Memory intact: a later `start` reruns the program.
- `prog_we` while `busy` -> word unchanged. `start` while `busy` -> ignored. With `SEQ_PERF_CNT_EN`, a 3-word program reads `retired_cnt`=3 once halted.
